// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// default hold limit and the round-robin winner search.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int HOLD_MAX_DEFAULT = 4;

  // Round-robin search: scan req ascending mod 4 starting at start.
  // Returns {found, index}; index is don't-care when found is 0.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < 4; k++) begin
      cand = start + k[1:0];
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/MUX_4_1.sv
// Existing 2-bit 4:1 gate-level mux. The select is decoded bit-reversed:
// s=2'b01 picks i2 and s=2'b10 picks i1.
module MUX_4_1 (
  input  logic [1:0] i0,
  input  logic [1:0] i1,
  input  logic [1:0] i2,
  input  logic [1:0] i3,
  input  logic [1:0] s,
  output logic [1:0] y
);

  logic sel0;
  logic sel1;
  logic sel2;
  logic sel3;

  assign sel0 = ~s[0] & ~s[1];
  assign sel1 = ~s[0] &  s[1];
  assign sel2 =  s[0] & ~s[1];
  assign sel3 =  s[0] &  s[1];

  assign y = ({2{sel0}} & i0) | ({2{sel1}} & i1) | ({2{sel2}} & i2) | ({2{sel3}} & i3);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 2-bit output channel among four requesters.
// Each grant is capped at HOLD_MAX accepted beats, then the pointer rotates.
//
// Handshake: a beat is transferred on a rising edge where out_valid and
// out_ready are both 1. out_valid follows the granted requester's req bit
// combinationally; out_ready may stall indefinitely and the grant, beat count
// and dout are all held while it does.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] din0,
  input  logic [1:0] din1,
  input  logic [1:0] din2,
  input  logic [1:0] din3,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] dout,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic [1:0] mux_sel
);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] count;

  logic [1:0] mux_y;
  logic       holder_req;
  logic       accept;
  logic       last_beat;
  logic       rel;
  logic [1:0] search_start;
  logic       win_found;
  logic [1:0] win_idx;

  MUX_4_1 u_mux (
    .i0 (din0),
    .i1 (din1),
    .i2 (din2),
    .i3 (din3),
    .s  (mux_sel),
    .y  (mux_y)
  );

  // Handshake, release detection and round-robin winner search.
  // On release the search starts just past the holder, so it is tried last.
  always_comb begin
    holder_req   = req[gnt_idx];
    out_valid    = (state == ST_BUSY) && holder_req;
    dout         = out_valid ? mux_y : 2'b00;
    accept       = out_valid && out_ready;
    last_beat    = accept && (count == CNT_W'(HOLD_MAX - 1));
    rel          = (state == ST_BUSY) && (!holder_req || last_beat);
    search_start = (state == ST_BUSY) ? (gnt_idx + 2'd1) : ptr;
    {win_found, win_idx} = rr_pick(req, search_start);
  end

  // Grant FSM: registered grant, index, mux select, pointer and beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      mux_sel <= 2'b00;
      ptr     <= 2'd0;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state   <= ST_BUSY;
            gnt     <= 4'b0001 << win_idx;
            gnt_idx <= win_idx;
            mux_sel <= {win_idx[0], win_idx[1]};
            count   <= '0;
          end
        end
        ST_BUSY: begin
          if (rel) begin
            ptr   <= gnt_idx + 2'd1;
            count <= '0;
            if (win_found) begin
              gnt     <= 4'b0001 << win_idx;
              gnt_idx <= win_idx;
              mux_sel <= {win_idx[0], win_idx[1]};
            end else begin
              state <= ST_IDLE;
              gnt   <= 4'b0000;
            end
          end else if (accept) begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule
